// File: rtl/pll_reset_sequencer.sv
// Sequences iCE40 PLL reset, lock qualification and settle delay before releasing core reset.
// All outputs registered with state; lock input passes a 2-flop synchronizer (2 cycles); no backpressure.
module pll_reset_sequencer #(
   parameter int PLL_RESET_CYCLES = 8,
   parameter int LOCK_WINDOW      = 4,
   parameter int RELEASE_DELAY    = 128,
   parameter int LOCK_TIMEOUT     = 65535,
   parameter int MAX_RETRIES      = 3
) (
   input  logic       clk_12mhz,
   input  logic       reset_n,
   input  logic       run_req,
   input  logic       pll_locked,
   output logic       pll_resetb,
   output logic       core_reset_n,
   output logic [2:0] state,
   output logic       fault,
   output logic [1:0] retry_count
);

   localparam int RST_W  = $clog2(PLL_RESET_CYCLES + 1);
   localparam int LOCK_W = $clog2(LOCK_WINDOW + 1);
   localparam int DLY_W  = $clog2(RELEASE_DELAY + 1);
   localparam int TO_W   = $clog2(LOCK_TIMEOUT + 1);

   localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(PLL_RESET_CYCLES - 1);
   localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_WINDOW - 1);
   localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(RELEASE_DELAY - 1);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_OFF       = 3'd0,
      ST_PLL_RST   = 3'd1,
      ST_WAIT_LOCK = 3'd2,
      ST_SETTLE    = 3'd3,
      ST_RUN       = 3'd4,
      ST_FAULT     = 3'd5
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_lock_meta;
   logic              r_lock_s;
   logic [RST_W-1:0]  r_rst_cnt;
   logic [RST_W-1:0]  w_rst_cnt_nxt;
   logic [LOCK_W-1:0] r_lock_cnt;
   logic [LOCK_W-1:0] w_lock_cnt_nxt;
   logic [DLY_W-1:0]  r_dly_cnt;
   logic [DLY_W-1:0]  w_dly_cnt_nxt;
   logic [TO_W-1:0]   r_to_cnt;
   logic [TO_W-1:0]   w_to_cnt_nxt;
   logic [1:0]        r_retry_count;
   logic [1:0]        w_retry_nxt;
   logic              r_pll_resetb;
   logic              r_core_reset_n;
   logic              r_fault;
   logic              w_pll_resetb_nxt;
   logic              w_core_reset_n_nxt;
   logic              w_fault_nxt;

   // Counters default to zero so every state entry starts them cleared.
   always_comb begin
      w_state_nxt    = r_state;
      w_rst_cnt_nxt  = '0;
      w_lock_cnt_nxt = '0;
      w_dly_cnt_nxt  = '0;
      w_to_cnt_nxt   = '0;
      w_retry_nxt    = r_retry_count;
      if (!run_req && (r_state != ST_OFF)) begin
         w_state_nxt = ST_OFF;
      end else begin
         case (r_state)
            ST_OFF: begin
               if (run_req) begin
                  w_state_nxt = ST_PLL_RST;
                  w_retry_nxt = 2'd0;
               end
            end
            ST_PLL_RST: begin
               if (r_rst_cnt == RST_LAST) w_state_nxt = ST_WAIT_LOCK;
               else                       w_rst_cnt_nxt = r_rst_cnt + 1'b1;
            end
            ST_WAIT_LOCK: begin
               if (r_lock_s && (r_lock_cnt == LOCK_LAST)) begin
                  w_state_nxt = ST_SETTLE;
               end else if (r_to_cnt == TO_LAST) begin
                  if (32'(r_retry_count) == MAX_RETRIES) begin
                     w_state_nxt = ST_FAULT;
                  end else begin
                     w_state_nxt = ST_PLL_RST;
                     w_retry_nxt = (r_retry_count == 2'd3) ? 2'd3 : r_retry_count + 2'd1;
                  end
               end else begin
                  w_to_cnt_nxt   = r_to_cnt + 1'b1;
                  w_lock_cnt_nxt = r_lock_s ? r_lock_cnt + 1'b1 : '0;
               end
            end
            ST_SETTLE: begin
               if (!r_lock_s) begin
                  w_state_nxt = ST_WAIT_LOCK;
               end else if (r_dly_cnt == DLY_LAST) begin
                  w_state_nxt = ST_RUN;
                  w_retry_nxt = 2'd0;
               end else begin
                  w_dly_cnt_nxt = r_dly_cnt + 1'b1;
               end
            end
            ST_RUN: begin
               if (!r_lock_s) w_state_nxt = ST_PLL_RST;
            end
            ST_FAULT: w_state_nxt = ST_FAULT;
            default:  w_state_nxt = ST_OFF;
         endcase
      end
      w_pll_resetb_nxt   = (w_state_nxt == ST_WAIT_LOCK) || (w_state_nxt == ST_SETTLE) ||
                           (w_state_nxt == ST_RUN);
      w_core_reset_n_nxt = (w_state_nxt == ST_RUN);
      w_fault_nxt        = (w_state_nxt == ST_FAULT);
   end

   always_ff @(posedge clk_12mhz) begin
      if (!reset_n) begin
         r_state        <= ST_OFF;
         r_lock_meta    <= 1'b0;
         r_lock_s       <= 1'b0;
         r_rst_cnt      <= '0;
         r_lock_cnt     <= '0;
         r_dly_cnt      <= '0;
         r_to_cnt       <= '0;
         r_retry_count  <= 2'd0;
         r_pll_resetb   <= 1'b0;
         r_core_reset_n <= 1'b0;
         r_fault        <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_lock_meta    <= pll_locked;
         r_lock_s       <= r_lock_meta;
         r_rst_cnt      <= w_rst_cnt_nxt;
         r_lock_cnt     <= w_lock_cnt_nxt;
         r_dly_cnt      <= w_dly_cnt_nxt;
         r_to_cnt       <= w_to_cnt_nxt;
         r_retry_count  <= w_retry_nxt;
         r_pll_resetb   <= w_pll_resetb_nxt;
         r_core_reset_n <= w_core_reset_n_nxt;
         r_fault        <= w_fault_nxt;
      end
   end

   assign state        = r_state;
   assign pll_resetb   = r_pll_resetb;
   assign core_reset_n = r_core_reset_n;
   assign fault        = r_fault;
   assign retry_count  = r_retry_count;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Randomized scoreboard bench for pll_reset_sequencer: a behavioural model queues expected outputs per edge.
module tb_pll_reset_sequencer;

   localparam int PRC = 8;
   localparam int LW  = 4;
   localparam int RD  = 128;
   localparam int LTO = 16;
   localparam int MR  = 2;

   localparam int S_OFF = 0, S_PLLRST = 1, S_WAIT = 2, S_SETTLE = 3, S_RUN = 4, S_FAULT = 5;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       run_req = 1'b0;
   logic       pll_locked = 1'b0;
   logic       pll_resetb;
   logic       core_reset_n;
   logic [2:0] state;
   logic       fault;
   logic [1:0] retry_count;

   int total = 0;
   int bad   = 0;

   logic [7:0] exp_q[$];

   // model state: spec-level view (time in state, lock streak, retries)
   int m_state = S_OFF;
   int m_age = 0;
   int m_streak = 0;
   int m_retry = 0;
   bit m_meta = 1'b0;
   bit m_sync = 1'b0;

   pll_reset_sequencer #(
      .PLL_RESET_CYCLES(PRC),
      .LOCK_WINDOW(LW),
      .RELEASE_DELAY(RD),
      .LOCK_TIMEOUT(LTO),
      .MAX_RETRIES(MR)
   ) dut (
      .clk_12mhz(clk),
      .reset_n(reset_n),
      .run_req(run_req),
      .pll_locked(pll_locked),
      .pll_resetb(pll_resetb),
      .core_reset_n(core_reset_n),
      .state(state),
      .fault(fault),
      .retry_count(retry_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic bit m_pll_on();
      return (m_state == S_WAIT) || (m_state == S_SETTLE) || (m_state == S_RUN);
   endfunction

   function automatic logic [7:0] model_out();
      logic [2:0] s;
      logic [1:0] r;
      s = 3'(m_state);
      r = 2'(m_retry);
      return {s, m_pll_on(), (m_state == S_RUN), (m_state == S_FAULT), r};
   endfunction

   task automatic model_step(input logic rn, input logic rr, input logic pl);
      int  ns;
      bit  ls;
      if (!rn) begin
         m_state = S_OFF; m_age = 0; m_streak = 0; m_retry = 0;
         m_meta = 1'b0; m_sync = 1'b0;
         return;
      end
      ls     = m_sync;
      m_sync = m_meta;
      m_meta = pl;
      ns     = m_state;
      if (!rr && m_state != S_OFF) begin
         ns = S_OFF;
      end else begin
         case (m_state)
            S_OFF: if (rr) begin ns = S_PLLRST; m_retry = 0; end
            S_PLLRST: if (m_age + 1 == PRC) ns = S_WAIT;
            S_WAIT: begin
               m_streak = ls ? m_streak + 1 : 0;
               if (m_streak == LW) ns = S_SETTLE;
               else if (m_age + 1 == LTO) begin
                  if (m_retry == MR) ns = S_FAULT;
                  else begin
                     m_retry = (m_retry < 3) ? m_retry + 1 : 3;
                     ns = S_PLLRST;
                  end
               end
            end
            S_SETTLE: begin
               if (!ls) ns = S_WAIT;
               else if (m_age + 1 == RD) begin ns = S_RUN; m_retry = 0; end
            end
            S_RUN: if (!ls) ns = S_PLLRST;
            default: ns = m_state;
         endcase
      end
      if (ns != m_state) begin m_age = 0; m_streak = 0; end
      else m_age++;
      m_state = ns;
   endtask

   task automatic cyc(input logic rn, input logic rr, input logic pl);
      reset_n    = rn;
      run_req    = rr;
      pll_locked = pl;
      model_step(rn, rr, pl);
      exp_q.push_back(model_out());
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // monitor: one expectation per edge, compared at the following falling edge
   initial begin
      logic [7:0] e;
      logic [7:0] a;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {state, pll_resetb, core_reset_n, fault, retry_count};
            total++;
            if (a !== e) begin
               bad++;
               $display("FAIL scoreboard t=%0t state=%0d/%0d pll_resetb=%b/%b core_reset_n=%b/%b fault=%b/%b retry=%0d/%0d",
                        $time, a[7:5], e[7:5], a[4], e[4], a[3], e[3], a[2], e[2], a[1:0], e[1:0]);
            end
         end
      end
   end

   task automatic seq_to_run(input int glitch_age, output int lat, output int low_cnt, output bit ok);
      bit glitched;
      bit pl;
      glitched = 1'b0;
      lat = 0; low_cnt = 0;
      for (int i = 0; i < 600; i++) begin
         if (m_state == S_RUN) break;
         pl = m_pll_on();
         if (!glitched && glitch_age >= 0 && m_state == S_SETTLE && m_age == glitch_age) begin
            pl = 1'b0;
            glitched = 1'b1;
         end
         cyc(1'b1, 1'b1, pl);
         lat = pl ? lat + 1 : 0;
         if (state == 3'd1 && pll_resetb == 1'b0) low_cnt++;
      end
      ok = (m_state == S_RUN);
   endtask

   initial begin
      int  lat, low_cnt, n, waits, visits;
      int  vis_retry[4];
      bit  ok;
      logic [2:0] prev;

      // reset held with run_req high
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
      chk("reset_state", int'(state), 0);
      chk("reset_fault", int'(fault), 0);

      // clean bring-up
      seq_to_run(-1, lat, low_cnt, ok);
      chk("bringup_reached_run", int'(ok), 1);
      chk("pll_resetb_low_cycles", low_cnt, PRC);
      chk("bringup_latency", lat, 134);
      chk("bringup_core_reset_n", int'(core_reset_n), 1);
      chk("bringup_state", int'(state), 4);

      // lock loss in RUN, then re-sequence with a one-cycle glitch mid-SETTLE
      n = 0;
      do begin cyc(1'b1, 1'b1, 1'b0); n++; end while (state != 3'd1 && n < 10);
      chk("run_drop_edges", n, 3);
      chk("run_drop_core_reset_n", int'(core_reset_n), 0);
      seq_to_run(50, lat, low_cnt, ok);
      chk("glitch_reached_run", int'(ok), 1);
      chk("glitch_latency", lat, 134);
      chk("glitch_retry", int'(retry_count), 0);

      // lock never arrives: retries then FAULT
      cyc(1'b1, 1'b0, 1'b0);
      chk("off_state", int'(state), 0);
      waits = 0; visits = 0; prev = state;
      for (int i = 0; i < 4; i++) vis_retry[i] = -1;
      for (int i = 0; i < 200 && fault !== 1'b1; i++) begin
         cyc(1'b1, 1'b1, 1'b0);
         if (state == 3'd2) begin
            waits++;
            if (prev != 3'd2) begin
               if (visits < 4) vis_retry[visits] = int'(retry_count);
               visits++;
            end
         end
         prev = state;
      end
      chk("timeout_wait_cycles", waits, 3 * LTO);
      chk("timeout_visits", visits, 3);
      for (int i = 0; i < 3; i++) chk("timeout_visit_retry", vis_retry[i], i);
      chk("fault_state", int'(state), 5);
      chk("fault_flag", int'(fault), 1);
      chk("fault_retry", int'(retry_count), 2);
      cyc(1'b1, 1'b0, 1'b0);
      chk("fault_exit_state", int'(state), 0);
      chk("fault_exit_flag", int'(fault), 0);

      // randomized traffic: lock follows the PLL with random dropouts, occasional run_req/reset pulses
      for (int i = 0; i < 1500; i++) begin
         logic rn, rr, pl;
         rn = ($urandom_range(0, 199) != 0);
         rr = ($urandom_range(0, 99) >= 2);
         pl = m_pll_on();
         if ($urandom_range(0, 99) < 3) pl = ~pl;
         cyc(rn, rr, pl);
      end

      // run_req drop and reassert from RUN
      cyc(1'b1, 1'b0, 1'b0);
      seq_to_run(-1, lat, low_cnt, ok);
      chk("rerun_reached_run", int'(ok), 1);
      cyc(1'b1, 1'b0, 1'b1);
      chk("runreq_drop_state", int'(state), 0);
      chk("runreq_drop_pll_resetb", int'(pll_resetb), 0);
      chk("runreq_drop_core_reset_n", int'(core_reset_n), 0);
      cyc(1'b1, 1'b1, 1'b0);
      chk("runreq_reassert_state", int'(state), 1);

      @(negedge clk);
      #1;
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Controller for the iCE40 PLL and core reset on the board top.
- Holds the PLL in reset on host request, waits for a qualified lock, then counts a settle delay before releasing the core reset.
- Re-sequences on lock loss and retries on lock timeout; reports a fault after too many retries.
- Runs on the 12 MHz reference clock, which keeps running while the PLL is held in reset.

Parameters:
- PLL_RESET_CYCLES, 8: cycles pll_resetb is held low per attempt (>=1).
- LOCK_WINDOW, 4: consecutive synchronized-lock-high cycles required (>=1).
- RELEASE_DELAY, 128: settle cycles after lock qualification before core release (>=1).
- LOCK_TIMEOUT, 65535: WAIT_LOCK cycles allowed before an attempt fails (>=1).
- MAX_RETRIES, 3: failed attempts tolerated before FAULT.

Ports:
- clk_12mhz, in, 1: sole clock; board reference clock.
- reset_n, in, 1: synchronous, active-low reset.
- run_req, in, 1: host run request (inverted DTR), level-sensitive, synchronous to clk_12mhz.
- pll_locked, in, 1: PLL LOCK output, asynchronous; two-flop synchronized internally (lock_s).
- pll_resetb, out, 1: drives PLL RESETB; 1 lets the PLL run.
- core_reset_n, out, 1: active-low reset to the core.
- state, out, 3: current state encoding.
- fault, out, 1: high only in FAULT.
- retry_count, out, 2: failed attempts since the last RUN entry; saturates at 3.

Behaviour:
- State encoding: OFF=0, PLL_RST=1, WAIT_LOCK=2, SETTLE=3, RUN=4, FAULT=5.
- All outputs are registered and change on the same edge as the state.
- Reset (reset_n=0 at an edge) sets: state=OFF, pll_resetb=0, core_reset_n=0, fault=0, retry_count=0. All counters and both synchronizer flops clear.
- Priority 1: reset_n low.
- Priority 2: run_req low in any non-OFF state. Next state is OFF, pll_resetb=0, core_reset_n=0; retry_count is kept.
- OFF:
  - pll_resetb=0, core_reset_n=0.
  - run_req high → PLL_RST; rst_cnt=0; retry_count=0.
- PLL_RST:
  - pll_resetb=0; rst_cnt increments each cycle.
  - When rst_cnt==PLL_RESET_CYCLES-1 → WAIT_LOCK with pll_resetb=1, lock_cnt=0, to_cnt=0.
  - pll_resetb is therefore low for exactly PLL_RESET_CYCLES cycles.
- WAIT_LOCK:
  - lock_s high: lock_cnt increments. lock_s low: lock_cnt clears to 0.
  - lock_s high and lock_cnt==LOCK_WINDOW-1 → SETTLE, dly_cnt=0.
  - Otherwise to_cnt increments. When to_cnt==LOCK_TIMEOUT-1:
    - retry_count==MAX_RETRIES → FAULT.
    - Otherwise retry_count+1 and go to PLL_RST.
  - If lock qualification and timeout happen on the same cycle, lock wins.
- SETTLE:
  - core_reset_n=0; dly_cnt increments.
  - lock_s low → WAIT_LOCK with lock_cnt=0, to_cnt=0; retry_count unchanged.
  - dly_cnt==RELEASE_DELAY-1 with lock_s high → RUN with core_reset_n=1; retry_count clears to 0.
- RUN:
  - core_reset_n=1, pll_resetb=1.
  - lock_s low → PLL_RST, rst_cnt=0. core_reset_n=0 and pll_resetb=0 on that same edge.
- FAULT:
  - pll_resetb=0, core_reset_n=0, fault=1.
  - Exits only via run_req low, to OFF.
- Latency with defaults:
  - Number the first edge that samples pll_locked=1 (held steady) during WAIT_LOCK as edge 1.
  - lock_s is high from edge 2; SETTLE is entered at edge 6; core_reset_n rises at edge 134.
- Counter widths are $clog2 of (limit+1). Counters never wrap; each clears on state entry.
- pll_locked glitches shorter than one clock may be missed by design.

Test Plan:
- reset_n=0 for 3 cycles with run_req=1 → state=0, pll_resetb=0, core_reset_n=0, fault=0. First edge after release: state=1.
- Defaults, run_req=1, pll_locked tied to 1 once pll_resetb rises → pll_resetb low 8 cycles. core_reset_n rises 134 edges after the first edge sampling lock in WAIT_LOCK; state=4; retry_count=0.
- Drop pll_locked for 1 cycle mid-SETTLE (dly_cnt=50) → state returns to 2. Core release occurs 134 edges after lock is restored; retry_count still 0.
- LOCK_TIMEOUT=16, MAX_RETRIES=2, pll_locked=0 → three WAIT_LOCK visits of 16 cycles each; retry_count goes 0→1→2, then state=5 and fault=1. run_req=0 → state=0 and fault=0 next edge.
- In RUN, drop pll_locked → two edges later state=1 and core_reset_n=0 on the same edge. Full re-sequence then releases again.
- In RUN, deassert run_req → next edge state=0, pll_resetb=0, core_reset_n=0. Reassert → state=1 next edge.
